// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that fills instruction memory and holds the core in reset until a checked load completes
// Ports: clk/reset (sync, active-high); start pulse; in_valid/in_data/in_ready byte stream;
//        mem_we/mem_addr/mem_wdata big-endian word write port; core_hold, done, error status.
module imem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;
  localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 4);
  logic [2:0]        r_state;
  logic [7:0]        r_len_hi;
  logic [ADDR_W-2:0] r_len;
  logic [ADDR_W-2:0] r_wcnt;
  logic [1:0]        r_bcnt;
  logic [31:0]       r_shift;
  logic [7:0]        r_xor;
  logic [15:0]       w_len16;
  logic [ADDR_W-2:0] w_wnext;
  logic              w_acc;
  assign w_len16 = {r_len_hi, in_data};
  assign w_wnext = r_wcnt + 1'b1;
  assign w_acc   = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len_hi <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_xor    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR:
          if (start) begin
            r_state <= S_LEN_HI;
            r_wcnt  <= '0;
            r_xor   <= '0;
            r_bcnt  <= '0;
          end
        S_LEN_HI:
          if (w_acc) begin
            r_len_hi <= in_data;
            r_state  <= S_LEN_LO;
          end
        S_LEN_LO:
          if (w_acc) begin
            r_len   <= w_len16[ADDR_W-2:0];
            r_state <= (w_len16 > MAX_WORDS) ? S_ERR : (w_len16 == 16'd0) ? S_CHECK : S_DATA;
          end
        S_DATA:
          if (w_acc) begin
            r_shift <= {r_shift[23:0], in_data};
            r_xor   <= r_xor ^ in_data;
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) r_state <= S_WRITE;
          end
        S_WRITE: begin
          r_wcnt  <= w_wnext;
          r_state <= (w_wnext == r_len) ? S_CHECK : S_DATA;
        end
        S_CHECK:
          if (w_acc) r_state <= (in_data == r_xor) ? S_DONE : S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // Address uses the pre-increment counter: the word index being written this cycle.
  assign in_ready  = (r_state == S_LEN_HI) | (r_state == S_LEN_LO) | (r_state == S_DATA) | (r_state == S_CHECK);
  assign mem_we    = r_state == S_WRITE;
  assign mem_addr  = {r_wcnt[ADDR_W-3:0], 2'b00};
  assign mem_wdata = r_shift;
  assign core_hold = r_state != S_DONE;
  assign done      = r_state == S_DONE;
  assign error     = r_state == S_ERR;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, mem_we, core_hold, done, error;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  int n_chk = 0;
  int n_fail = 0;
  int nw = 0;
  int viol = 0;
  int base;
  bit gap = 0;
  logic [6:0]  wa [0:63];
  logic [31:0] wd [0:63];
  imem_loader #(.MEM_BYTES(128), .ADDR_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem_we) begin
      if (nw < 64) begin
        wa[nw] = mem_addr;
        wd[nw] = mem_wdata;
      end
      nw = nw + 1;
      if (in_ready) viol = viol + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input logic [7:0] b);
    bit ok = 0;
    if (gap) begin
      in_valid = 0;
      @(negedge clk);
    end
    in_valid = 1;
    in_data = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = in_ready;
      @(negedge clk);
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
  endtask
  task automatic send_stream(input logic [7:0] cs);
    send(8'h00); send(8'h02);
    send(8'h00); send(8'h00); send(8'h00); send(8'h13);
    send(8'h00); send(8'h50); send(8'h00); send(8'h93);
    send(cs);
    in_valid = 0;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {25'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_core_hold"}, {31'd0, core_hold}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask
  task automatic chk_two_writes(input string tag);
    chk({tag, "_nwrites"}, nw - base, 32'd2);
    chk({tag, "_addr0"}, {25'd0, wa[base]}, 32'h00);
    chk({tag, "_data0"}, wd[base], 32'h00000013);
    chk({tag, "_addr1"}, {25'd0, wa[base+1]}, 32'h04);
    chk({tag, "_data1"}, wd[base+1], 32'h00500093);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 0;
    @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);
    base = nw;
    pulse_start();
    chk("lenhi_ready", {31'd0, in_ready}, 32'd1);
    send_stream(8'hD0);
    chk_two_writes("norm");
    chk("norm_done", {31'd0, done}, 32'd1);
    chk("norm_hold", {31'd0, core_hold}, 32'd0);
    chk("norm_err", {31'd0, error}, 32'd0);
    base = nw;
    pulse_start();
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_hold", {31'd0, core_hold}, 32'd1);
    send_stream(8'hD1);
    chk_two_writes("badcs");
    chk("badcs_err", {31'd0, error}, 32'd1);
    chk("badcs_hold", {31'd0, core_hold}, 32'd1);
    chk("badcs_done", {31'd0, done}, 32'd0);
    base = nw;
    pulse_start();
    chk("err_cleared", {31'd0, error}, 32'd0);
    send(8'h00); send(8'h21);
    in_valid = 0;
    chk("ovf_err", {31'd0, error}, 32'd1);
    chk("ovf_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ovf_ready_later", {31'd0, in_ready}, 32'd0);
    chk("ovf_nwrites", nw - base, 32'd0);
    base = nw;
    pulse_start();
    send(8'h00); send(8'h20);
    send(8'h00);
    in_valid = 0;
    chk("max_len_ok", {31'd0, error}, 32'd0);
    base = nw;
    viol = 0;
    gap = 1;
    reset = 1;
    @(negedge clk);
    reset = 0;
    pulse_start();
    send_stream(8'hD0);
    gap = 0;
    chk_two_writes("gap");
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_we_ready", viol, 32'd0);
    base = nw;
    pulse_start();
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    in_valid = 0;
    reset = 1;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 0;
    @(negedge clk);
    chk("midrst_nwrites", nw - base, 32'd0);
    pulse_start();
    send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h44);
    in_valid = 0;
    chk("reload_nwrites", nw - base, 32'd1);
    chk("reload_addr", {25'd0, wa[base]}, 32'h00);
    chk("reload_data", wd[base], 32'h11223344);
    chk("reload_done", {31'd0, done}, 32'd1);
    base = nw;
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00);
    in_valid = 0;
    chk("empty_nwrites", nw - base, 32'd0);
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_hold", {31'd0, core_hold}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
